// File: rtl/nco_param.sv
// Quadrature NCO: phase accumulator, phase offset, then a registered sine LUT lookup.
// A sample launched by en appears on sine_out/cosine_out two clocks later with out_valid.
module nco_param #(
  parameter int ACC_W  = 24,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ACC_W-1:0]  fcw_in,
  input  logic              fcw_load,
  input  logic [LUT_AW-1:0] poff_in,
  input  logic              phase_clr,
  output logic [OUT_W-1:0]  sine_out,
  output logic [OUT_W-1:0]  cosine_out,
  output logic              out_valid,
  output logic              wrap_out
);

  localparam int LUT_N  = 1 << LUT_AW;
  localparam int AMP    = (1 << (OUT_W - 1)) - 1;
  localparam int STAGES = 2;
  localparam real PI    = 3.14159265358979323846;
  localparam logic [LUT_AW-1:0] QTR = LUT_AW'(LUT_N / 4);

  typedef logic [LUT_N-1:0][OUT_W-1:0] lut_t;

  // Taylor series is only evaluated on [0, pi/2], where 12 terms are well past double precision.
  function automatic real sin_q1(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Quadrant folding keeps the table exactly odd/symmetric; magnitudes round half away from zero.
  function automatic lut_t gen_lut();
    lut_t t;
    int   q;
    int   r;
    int   idx;
    int   mag;
    real  ang;
    t = '0;
    for (int k = 0; k < LUT_N; k++) begin
      q   = k / (LUT_N / 4);
      r   = k % (LUT_N / 4);
      idx = (q % 2 == 1) ? (LUT_N / 4 - r) : r;
      ang = 2.0 * PI * real'(idx) / real'(LUT_N);
      mag = $rtoi(real'(AMP) * sin_q1(ang) + 0.5);
      t[k] = (q >= 2) ? OUT_W'(-mag) : OUT_W'(mag);
    end
    return t;
  endfunction

  localparam lut_t LUT = gen_lut();

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  fcw_q, fcw_d;
  logic [ACC_W:0]    acc_sum;
  logic              wrap_q, wrap_d;
  logic [LUT_AW-1:0] addr_q, addr_d;
  logic [LUT_AW-1:0] cos_addr;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [OUT_W-1:0]  sin_q, sin_d;
  logic [OUT_W-1:0]  cos_q, cos_d;

  always_comb begin
    acc_sum    = {1'b0, acc_q} + {1'b0, fcw_q};
    fcw_d      = fcw_load ? fcw_in : fcw_q;
    acc_d      = acc_q;
    if (phase_clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_sum[ACC_W-1:0];
    wrap_d     = en & ~phase_clr & acc_sum[ACC_W];
    // Address uses the pre-update accumulator, so a clear on a launch edge only hits the next sample.
    addr_d     = en ? (acc_q[ACC_W-1 -: LUT_AW] + poff_in) : addr_q;
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], en};
    cos_addr   = addr_q + QTR;
    sin_d      = vld_pipe_q[1] ? LUT[addr_q]   : sin_q;
    cos_d      = vld_pipe_q[1] ? LUT[cos_addr] : cos_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q      <= '0;
      fcw_q      <= '0;
      wrap_q     <= 1'b0;
      addr_q     <= '0;
      vld_pipe_q <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      fcw_q      <= fcw_d;
      wrap_q     <= wrap_d;
      addr_q     <= addr_d;
      vld_pipe_q <= vld_pipe_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
    end
  end

  assign sine_out   = sin_q;
  assign cosine_out = cos_q;
  assign out_valid  = vld_pipe_q[STAGES];
  assign wrap_out   = wrap_q;

endmodule

// File: tb/tb_nco_param.sv
// Directed bench for nco_param at default parameters; expected samples come from a
// hand-written table of 127*sin at multiples of 16 LUT steps.
module tb_nco_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [23:0] fcw_in;
  logic        fcw_load;
  logic [7:0]  poff_in;
  logic        phase_clr;
  logic [7:0]  sine_out;
  logic [7:0]  cosine_out;
  logic        out_valid;
  logic        wrap_out;

  int n_chk = 0;
  int n_err = 0;

  int sin16 [16] = '{0, 49, 90, 117, 127, 117, 90, 49, 0, -49, -90, -117, -127, -117, -90, -49};
  int g_addr[10] = '{0, 16, 32, 48, 80, 112, 144, 176, 32, 64};
  int h_en  [6]  = '{1, 0, 0, 1, 0, 0};
  int h_vld [6]  = '{0, 1, 0, 0, 1, 0};
  int h_sin [6]  = '{0, 49, 49, 49, 117, 117};
  int h_cos [6]  = '{0, 117, 117, 117, 49, 49};

  nco_param #(.ACC_W(24), .LUT_AW(8), .OUT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .fcw_in    (fcw_in),
    .fcw_load  (fcw_load),
    .poff_in   (poff_in),
    .phase_clr (phase_clr),
    .sine_out  (sine_out),
    .cosine_out(cosine_out),
    .out_valid (out_valid),
    .wrap_out  (wrap_out)
  );

  always #5 clk = ~clk;

  function automatic int lut(input int a);
    return sin16[(a % 256) / 16];
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int s, input int c);
    chk({tag, "_sin"}, int'($signed(sine_out)), s);
    chk({tag, "_cos"}, int'($signed(cosine_out)), c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; fcw_in = '0; fcw_load = 1'b0; poff_in = '0; phase_clr = 1'b0;
    tick(); tick();
    chk_out("rst", 0, 0);
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_wrap", int'(wrap_out), 0);

    // basic sweep, fcw = 1/16 turn
    reset = 1'b1; fcw_load = 1'b1; fcw_in = 24'h100000;
    tick();
    fcw_load = 1'b0; en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sweep_vld%0d", i), int'(out_valid), (i >= 2) ? 1 : 0);
      chk($sformatf("sweep_wrap%0d", i), int'(wrap_out), (i % 16 == 0) ? 1 : 0);
      if (i >= 2) chk_out($sformatf("sweep%0d", i), lut(16 * (i - 2)), lut(16 * (i - 2) + 64));
    end

    // fcw = 0, phase offset only
    en = 1'b0; fcw_load = 1'b1; fcw_in = '0; phase_clr = 1'b1;
    tick();
    fcw_load = 1'b0; phase_clr = 1'b0; poff_in = 8'd64; en = 1'b1;
    tick(); tick();
    chk_out("poff64_a", 127, 0);
    tick();
    chk_out("poff64_b", 127, 0);
    poff_in = 8'd128;
    tick();
    chk_out("poff128_lat", 127, 0);
    tick();
    chk_out("poff128_a", 0, -127);
    tick();
    chk_out("poff128_b", 0, -127);

    // Nyquist
    en = 1'b0; fcw_load = 1'b1; fcw_in = 24'h800000; phase_clr = 1'b1; poff_in = '0;
    tick();
    fcw_load = 1'b0; phase_clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("nyq_wrap%0d", i), int'(wrap_out), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("nyq_vld%0d", i), int'(out_valid), (i >= 2) ? 1 : 0);
      if (i >= 2) chk_out($sformatf("nyq%0d", i), 0, (i % 2 == 0) ? 127 : -127);
    end

    // mid-run fcw change, then clear together with en
    en = 1'b0; fcw_load = 1'b1; fcw_in = 24'h100000; phase_clr = 1'b1;
    tick();
    fcw_load = 1'b0; phase_clr = 1'b0; en = 1'b1; fcw_in = 24'h200000;
    for (int i = 1; i <= 11; i++) begin
      fcw_load  = (i == 3);
      phase_clr = (i == 8);
      poff_in   = (i >= 9) ? 8'd32 : 8'd0;
      tick();
      fcw_load = 1'b0; phase_clr = 1'b0;
      if (i >= 2) chk_out($sformatf("load%0d", i), lut(g_addr[i-2]), lut(g_addr[i-2] + 64));
    end

    // en gaps
    en = 1'b0; phase_clr = 1'b1; poff_in = 8'd16;
    tick();
    phase_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = h_en[i][0];
      tick();
      chk($sformatf("gap_vld%0d", i), int'(out_valid), h_vld[i]);
      if (i >= 1) chk_out($sformatf("gap%0d", i), h_sin[i], h_cos[i]);
    end

    // mid-run reset drops in-flight samples and clears fcw
    en = 1'b1; poff_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_out("mrst", 0, 0);
    chk("mrst_vld", int'(out_valid), 0);
    chk("mrst_wrap", int'(wrap_out), 0);
    reset = 1'b1;
    tick();
    chk("post_vld1", int'(out_valid), 0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("post_vld%0d", i), int'(out_valid), 1);
      chk_out($sformatf("post%0d", i), 0, 127);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
